dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width in bits, byte address.
REQ-002 SHALL have parameter DATA_W, default 32: data word width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports rN_valid, input, 1, for N=0 (core load/store port) and N=1 (loader/debug port): request present.
REQ-006 SHALL have ports rN_we, input, 1: write request when high, read when low.
REQ-007 SHALL have ports rN_lock, input, 1: requester keeps the grant after the current beat.
REQ-008 SHALL have ports rN_addr, input, ADDR_W, and rN_wdata, input, DATA_W: request address and write data.
REQ-009 SHALL have ports rN_ready, output, 1: request accepted this cycle.
REQ-010 SHALL have ports rN_rvalid, output, 1, and rN_rdata, output, DATA_W: read response.
REQ-011 SHALL have ports mem_en, mem_we, output, 1; mem_addr, output, ADDR_W; mem_wdata, output, DATA_W: memory command.
REQ-012 SHALL have port mem_rdata, input, DATA_W: memory read data, valid exactly one cycle after a read command.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0 and OWN1, where OWNn means requester n holds a locked grant.
REQ-014 SHALL decide the winner combinationally: in OWNn only requester n is eligible; in IDLE the winner follows the arbitration policy of REQ-024 and REQ-025.
REQ-015 SHALL accept at most one request per cycle, with rN_ready = rN_valid & winner==N.
REQ-016 SHALL drive mem_en = 1 only in cycles where a request is accepted, with mem_we/addr/wdata passed through from the winner in that same cycle (zero added latency).
REQ-017 SHALL, for an accepted read, assert the winner's rN_rvalid exactly one cycle later with rN_rdata = mem_rdata; the other port's rvalid stays 0.
REQ-018 SHALL hold rN_rdata at 0 when rN_rvalid is 0.
REQ-019 SHALL make these FSM transitions: accepted beat with rN_lock=1 goes to OWNn; in OWNn, an accepted beat with rN_lock=0 goes to IDLE; in OWNn, rN_valid=0 and rN_lock=0 goes to IDLE; otherwise the state holds.
REQ-020 SHALL, while in OWNn with rN_valid=0 and rN_lock=1, issue no memory command and keep the other requester stalled.
REQ-021 SHALL deassert the loser's ready; the loser's request persists unaccepted with no data loss, since requesters hold their signals until ready.
REQ-022 SHALL ensure an accepted write produces no rvalid.

Reset
REQ-023 SHALL, when rst=0 at a rising edge, set the FSM to IDLE, the round-robin pointer to 0 (port 0 favoured), the pending-read flags to 0, and every output to 0 (r0/r1_ready, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata); a read in flight at reset is dropped and no rvalid follows.

Configuration
REQ-024 SHALL compile in round-robin arbitration when DMEM_ARB_RR_EN is defined: on an IDLE contention the favoured port wins, and the pointer flips to the other port after every accepted beat that leaves the FSM in IDLE.
REQ-025 SHALL, when DMEM_ARB_RR_EN is undefined, use fixed priority with port 0 always winning IDLE contention and no pointer register.

Verification
REQ-026 SHALL cover this scenario: after reset, r0 read addr 0x8 with mem_rdata=0x14 -> r0_ready same cycle, r0_rvalid=1 and r0_rdata=0x14 next cycle, r1_rvalid=0.
REQ-027 SHALL cover this scenario: r0 and r1 both valid for 4 cycles in IDLE with RR_EN -> grants 0,1,0,1; without RR_EN -> grants 0,0,0,0.
REQ-028 SHALL cover this scenario: r1 writes 0x19 to 0x64 with r1_lock=1 for 3 beats while r0 is valid -> r0_ready=0 for all 3 beats, mem_we=1, mem_wdata=0x19; r0 is granted the cycle after r1's unlocked beat.
REQ-029 SHALL cover this scenario: in OWN1, r1_valid=0 and r1_lock=1 for 2 cycles -> mem_en=0 and r0_ready=0; r1_lock drops -> FSM goes to IDLE and r0 is granted next cycle.
REQ-030 SHALL cover this scenario: rst=0 asserted the cycle after an accepted read -> no rvalid on either port, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lock-based burst ownership and one-cycle read return.
// Optional round-robin arbitration in IDLE via `define DMEM_ARB_RR_EN (fixed priority, port 0 first, otherwise).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_pend0;
  logic   r_pend1;
  logic   w_acc0;
  logic   w_acc1;
  logic   w_acc;

`ifdef DMEM_ARB_RR_EN
  logic r_ptr;
`endif

  // Accepts are gated by rst so every command output reads 0 while reset is held.
  always_comb begin
    w_acc0 = 1'b0;
    w_acc1 = 1'b0;
    if (rst) begin
      case (r_state)
        OWN0: w_acc0 = r0_valid;
        OWN1: w_acc1 = r1_valid;
        default: begin
`ifdef DMEM_ARB_RR_EN
          if (r0_valid && r1_valid) begin
            w_acc0 = ~r_ptr;
            w_acc1 = r_ptr;
          end else begin
            w_acc0 = r0_valid;
            w_acc1 = r1_valid;
          end
`else
          w_acc0 = r0_valid;
          w_acc1 = r1_valid & ~r0_valid;
`endif
        end
      endcase
    end
  end

  assign w_acc = w_acc0 | w_acc1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc0 && r0_lock)      w_state_next = OWN0;
        else if (w_acc1 && r1_lock) w_state_next = OWN1;
      end
      OWN0: begin
        if ((w_acc0 && !r0_lock) || (!r0_valid && !r0_lock)) w_state_next = IDLE;
      end
      OWN1: begin
        if ((w_acc1 && !r1_lock) || (!r1_valid && !r1_lock)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend0 <= w_acc0 & ~r0_we;
      r_pend1 <= w_acc1 & ~r1_we;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (w_acc && (w_state_next == IDLE)) begin
      r_ptr <= ~r_ptr;
    end
  end
`endif

  assign r0_ready  = w_acc0;
  assign r1_ready  = w_acc1;
  assign mem_en    = w_acc;
  assign mem_we    = w_acc1 ? r1_we    : (w_acc0 & r0_we);
  assign mem_addr  = w_acc1 ? r1_addr  : (w_acc0 ? r0_addr  : '0);
  assign mem_wdata = w_acc1 ? r1_wdata : (w_acc0 ? r0_wdata : '0);

  // A read in flight across a reset edge must not surface, hence the rst gate.
  assign r0_rvalid = r_pend0 & rst;
  assign r1_rvalid = r_pend1 & rst;
  assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected commands/read returns, a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_valid = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_valid = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_ready, r0_rvalid, r1_ready, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  typedef struct {
    logic        port;
    logic [31:0] data;
  } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is address + 0x0C, returned one cycle after the command.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr + 32'h0C;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon
    cmd_t c;
    rd_t  r;
    if (mon_en) begin
      if (mem_en) begin
        chk("one_ready", 80'(r0_ready + r1_ready), 80'd1);
        chk("cmd_expected", 80'(cmd_q.size() != 0), 80'd1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          chk("cmd", {r1_ready, mem_we, mem_addr, mem_wdata}, {c.port, c.we, c.addr, c.wdata});
        end
      end else begin
        chk("ready_without_cmd", {r0_ready, r1_ready}, 80'd0);
      end
      if (r0_rvalid || r1_rvalid) begin
        chk("rvalid_both", 80'(r0_rvalid & r1_rvalid), 80'd0);
        chk("rd_expected", 80'(rd_q.size() != 0), 80'd1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          chk("rd", {r1_rvalid, (r1_rvalid ? r1_rdata : r0_rdata)}, {r.port, r.data});
        end
      end
      if (!r0_rvalid) chk("r0_rdata_idle", r0_rdata, 80'd0);
      if (!r1_rvalid) chk("r1_rdata_idle", r1_rdata, 80'd0);
    end
  end

  // One stimulus cycle; exp_port = -1 means no request may be accepted this cycle.
  task automatic beat(input logic v0, input logic we0, input logic lk0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic v1, input logic we1, input logic lk1,
                      input logic [31:0] a1, input logic [31:0] d1, input int exp_port, input bit rd_ok);
    cmd_t c;
    @(posedge clk); #1;
    r0_valid = v0; r0_we = we0; r0_lock = lk0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_lock = lk1; r1_addr = a1; r1_wdata = d1;
    if (exp_port >= 0) begin
      c.port  = (exp_port == 1);
      c.we    = c.port ? we1 : we0;
      c.addr  = c.port ? a1 : a0;
      c.wdata = c.port ? d1 : d0;
      cmd_q.push_back(c);
      if (!c.we && rd_ok) rd_q.push_back('{c.port, c.addr + 32'h0C});
    end
  endtask

  task automatic idle();
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flags"}, {r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_en, mem_we}, 80'd0);
    chk({tag, "_rdata"}, {r0_rdata, r1_rdata}, 80'd0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g[4];
`ifdef DMEM_ARB_RR_EN
    g = '{0, 1, 0, 1};
`else
    g = '{0, 0, 0, 0};
`endif
    // Reset with a request held: nothing may be accepted.
    rst = 1'b0; r0_valid = 1'b1; r0_addr = 32'h4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_init");
    rst = 1'b1; r0_valid = 1'b0; r0_addr = '0;
    mon_en = 1'b1;

    // Single read from port 0: rdata 0x14 one cycle later.
    beat(1, 0, 0, 32'h8, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    beat(0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 1, 1'b1);
    idle();

    // Four cycles of contention in IDLE.
    for (int i = 0; i < 4; i++)
      beat(1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, g[i], 1'b1);
    idle();

    // Port 1 locked write burst while port 0 waits.
    beat(0, 0, 0, 0, 0, 1, 1, 1, 32'h64, 32'h19, 1, 1'b1);
    beat(1, 0, 0, 32'h40, 0, 1, 1, 1, 32'h64, 32'h19, 1, 1'b1);
    beat(1, 0, 0, 32'h40, 0, 1, 1, 1, 32'h64, 32'h19, 1, 1'b1);
    beat(1, 0, 0, 32'h40, 0, 1, 1, 0, 32'h64, 32'h19, 1, 1'b1);
    beat(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();

    // Lock held with no request: port 0 stalls until the lock drops.
    beat(0, 0, 0, 0, 0, 1, 1, 1, 32'h70, 32'hAB, 1, 1'b1);
    beat(1, 0, 0, 32'h44, 0, 0, 0, 1, 0, 0, -1, 1'b1);
    beat(1, 0, 0, 32'h44, 0, 0, 0, 1, 0, 0, -1, 1'b1);
    beat(1, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0, -1, 1'b1);
    beat(1, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle();

    // Reset the cycle after a locked read: no rvalid, outputs 0, FSM back to IDLE.
    beat(0, 0, 0, 0, 0, 1, 0, 1, 32'h50, 0, 1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    r0_valid = 1'b1; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 32'h58;
    r1_valid = 1'b0; r1_lock = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset_inflight");
    beat(1, 0, 0, 32'h18, 0, 1, 0, 0, 32'h28, 0, 0, 1'b1);
    rst = 1'b1;
    idle();
    idle();
    idle();

    chk("cmd_q_drained", 80'(cmd_q.size()), 80'd0);
    chk("rd_q_drained", 80'(rd_q.size()), 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
